// File: rtl/twoscomp_serial.sv
// Digit-serial two's-complement pass/negate/abs unit, DIGIT bits per cycle, LSB first; result after N+1 cycles.
// Optional TWOSCOMP_SAT_EN: saturate the most-negative overflow case to max positive instead of wrapping.
module twoscomp_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);
    // Counter runs 0..N-1 for digits, then one finalize step at N before DONE.
    localparam logic [CW-1:0] LAST = CW'(N);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_neg;
    logic             r_ovf_pend;
    logic             r_ovf;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_res;

    logic             w_accept;
    logic             w_neg;
    logic             w_is_min;
    logic             w_last;
    logic [DIGIT-1:0] w_digit;
    logic [DIGIT-1:0] w_opnd;
    logic [DIGIT-1:0] w_sum;
    logic             w_cout;

    assign w_is_min = (d == {1'b1, {(WIDTH-1){1'b0}}});
    assign w_neg    = (mode == 2'b01) || ((mode == 2'b10) && d[WIDTH-1]);
    assign w_last   = (r_cnt == LAST);
    assign w_digit  = r_sr[DIGIT-1:0];
    assign w_opnd   = r_neg ? ~w_digit : w_digit;
    assign {w_cout, w_sum} = {1'b0, w_opnd} + {{DIGIT{1'b0}}, r_carry};

    assign out = r_res;
    assign ovf = r_ovf;

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_neg      <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_ovf      <= 1'b0;
            r_sr       <= '0;
            r_res      <= '0;
        end else if (w_accept) begin
            r_sr       <= d;
            r_neg      <= w_neg;
            r_carry    <= w_neg;
            r_cnt      <= '0;
            r_ovf_pend <= w_neg && w_is_min;
            r_ovf      <= 1'b0;
        end else if (r_state == S_RUN) begin
            if (!w_last) begin
                // Final carry-out of the top digit is intentionally dropped (mod 2^WIDTH).
                r_sr    <= WIDTH'({{DIGIT{1'b0}}, r_sr} >> DIGIT);
                r_res   <= WIDTH'({w_sum, r_res} >> DIGIT);
                r_carry <= w_cout;
                r_cnt   <= r_cnt + CW'(1);
            end else begin
                r_ovf <= r_ovf_pend;
`ifdef TWOSCOMP_SAT_EN
                if (r_ovf_pend) r_res <= {1'b0, {(WIDTH-1){1'b1}}};
`endif
            end
        end
    end

endmodule

// File: tb/tb_twoscomp_serial.sv
// Randomized bench for twoscomp_serial: 16/4 instance checked every cycle against a scoreboard, plus 8/1 and 8/8 instances.
module tb_twoscomp_serial;

    localparam int N16 = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, out_valid, out_ready, ovf;
    logic [15:0] d, out;
    logic [1:0]  mode;

    logic        iv8, or8;
    logic [7:0]  d8;
    logic [1:0]  m8;
    logic        a_rdy, a_vld, a_ovf, b_rdy, b_vld, b_ovf;
    logic [7:0]  a_out, b_out;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int hs_cnt = 0;
    logic [15:0] last_out;
    logic        last_ovf;

    typedef struct {
        logic [15:0] o;
        logic        v;
        int          acc;
    } exp_t;
    exp_t q[$];
    bit   seen = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    twoscomp_serial #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .d(d), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .ovf(ovf)
    );
    twoscomp_serial #(.WIDTH(8), .DIGIT(1)) u_a (
        .clk(clk), .reset_n(reset_n), .in_valid(iv8), .in_ready(a_rdy),
        .d(d8), .mode(m8), .out_valid(a_vld), .out_ready(or8),
        .out(a_out), .ovf(a_ovf)
    );
    twoscomp_serial #(.WIDTH(8), .DIGIT(8)) u_b (
        .clk(clk), .reset_n(reset_n), .in_valid(iv8), .in_ready(b_rdy),
        .d(d8), .mode(m8), .out_valid(b_vld), .out_ready(or8),
        .out(b_out), .ovf(b_ovf)
    );

    // Reference: plain modular arithmetic on a w-bit value.
    function automatic logic [16:0] model(input logic [15:0] x, input logic [1:0] m, input int w);
        logic [15:0] mask, minv, r;
        logic        neg, o;
        mask = (w == 16) ? 16'hFFFF : ((16'd1 << w) - 16'd1);
        minv = 16'd1 << (w - 1);
        x    = x & mask;
        neg  = (m == 2'b01) || ((m == 2'b10) && ((x & minv) != 16'd0));
        r    = neg ? ((16'd0 - x) & mask) : x;
        o    = neg && (x == minv);
`ifdef TWOSCOMP_SAT_EN
        if (o) r = minv - 16'd1;
`endif
        return {o, r};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
            seen = 0;
            check("rst_in_ready",  32'(in_ready),  32'd1);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out",       32'(out),       32'd0);
            check("rst_ovf",       32'(ovf),       32'd0);
        end else begin
            if (q.size() == 0) begin
                check("idle_in_ready",  32'(in_ready),  32'd1);
                check("idle_out_valid", 32'(out_valid), 32'd0);
            end else begin
                check("busy_in_ready", 32'(in_ready), 32'd0);
                if (out_valid) begin
                    if (!seen) begin
                        check("latency", 32'(cyc - q[0].acc), 32'(N16 + 1));
                        seen = 1;
                    end
                    check("out", 32'(out), 32'(q[0].o));
                    check("ovf", 32'(ovf), 32'(q[0].v));
                    if (out_ready) begin
                        last_out = out;
                        last_ovf = ovf;
                        hs_cnt++;
                        void'(q.pop_front());
                        seen = 0;
                    end
                end else if (cyc - q[0].acc > N16 + 1) begin
                    check("valid_late", 32'(cyc - q[0].acc), 32'(N16 + 1));
                end
            end
            if (in_valid && in_ready && q.size() == 0) begin
                logic [16:0] e;
                e = model(d, mode, 16);
                q.push_back('{o: e[15:0], v: e[16], acc: cyc + 1});
            end
        end
    end

    task automatic send(input logic [15:0] dd, input logic [1:0] mm);
        int n = 0;
        @(posedge clk); #2;
        d = dd; mode = mm; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #2;
        in_valid = 1'b0; d = 16'($urandom); mode = 2'($urandom);
    endtask

    task automatic finish_op(input int hold);
        int n  = 0;
        int h0 = hs_cnt;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check("valid_timeout", 32'd0, 32'd1);
        repeat (hold) begin
            @(posedge clk); #2;
            in_valid = 1'b1; d = 16'($urandom); mode = 2'($urandom);
            @(negedge clk);
        end
        @(posedge clk); #2;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
        check("one_handshake", 32'(hs_cnt - h0), 32'd1);
    endtask

    task automatic send8(input logic [7:0] dd, input logic [1:0] mm,
                         output logic [7:0] ao, output logic av, output int al,
                         output logic [7:0] bo, output logic bv, output int bl);
        int acc;
        bit ga = 0, gb = 0;
        ao = 8'h00; av = 1'b0; al = -1;
        bo = 8'h00; bv = 1'b0; bl = -1;
        @(posedge clk); #2;
        d8 = dd; m8 = mm; iv8 = 1'b1;
        @(negedge clk);
        check("a_in_ready", 32'(a_rdy), 32'd1);
        check("b_in_ready", 32'(b_rdy), 32'd1);
        acc = cyc + 1;
        @(posedge clk); #2;
        iv8 = 1'b0; d8 = 8'($urandom); m8 = 2'($urandom);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (a_vld && !ga) begin ga = 1; ao = a_out; av = a_ovf; al = cyc - acc; end
            if (b_vld && !gb) begin gb = 1; bo = b_out; bv = b_ovf; bl = cyc - acc; end
        end
    endtask

    logic [15:0] td[8];
    logic [1:0]  tm[8];
    logic [15:0] to[8];
    logic        tv[8];
    logic [15:0] minres16;
    logic [7:0]  minres8;

    initial begin
        logic [7:0]  ao, bo;
        logic        av, bv;
        int          al, bl;
        logic [16:0] e;
        logic [15:0] rd;

`ifdef TWOSCOMP_SAT_EN
        minres16 = 16'h7FFF; minres8 = 8'h7F;
`else
        minres16 = 16'h8000; minres8 = 8'h80;
`endif
        td[0] = 16'h0001; tm[0] = 2'b01; to[0] = 16'hFFFF;   tv[0] = 1'b0;
        td[1] = 16'h0000; tm[1] = 2'b01; to[1] = 16'h0000;   tv[1] = 1'b0;
        td[2] = 16'h8000; tm[2] = 2'b01; to[2] = minres16;   tv[2] = 1'b1;
        td[3] = 16'h8000; tm[3] = 2'b10; to[3] = minres16;   tv[3] = 1'b1;
        td[4] = 16'hFFF6; tm[4] = 2'b10; to[4] = 16'h000A;   tv[4] = 1'b0;
        td[5] = 16'h1234; tm[5] = 2'b10; to[5] = 16'h1234;   tv[5] = 1'b0;
        td[6] = 16'hBEEF; tm[6] = 2'b00; to[6] = 16'hBEEF;   tv[6] = 1'b0;
        td[7] = 16'hBEEF; tm[7] = 2'b11; to[7] = 16'hBEEF;   tv[7] = 1'b0;

        reset_n = 1'b0; in_valid = 1'b0; d = '0; mode = '0; out_ready = 1'b0;
        iv8 = 1'b0; d8 = '0; m8 = '0; or8 = 1'b1;

        check("model_pin_neg1",  32'(model(16'h0001, 2'b01, 16)), 32'h0_FFFF);
        check("model_pin_abs",   32'(model(16'hFFF6, 2'b10, 16)), 32'h0_000A);
        check("model_pin_neg8",  32'(model(16'h0005, 2'b01, 8)),  32'h0_00FB);
        check("model_pin_min",   32'(model(16'h8000, 2'b01, 16)), 32'({1'b1, minres16}));

        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            send(td[i], tm[i]);
            finish_op((i == 7) ? 6 : 0);
            check("dir_out", 32'(last_out), 32'(to[i]));
            check("dir_ovf", 32'(last_ovf), 32'(tv[i]));
        end

        send(16'h0123, 2'b01);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_in_ready",  32'(in_ready),  32'd1);
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_out",       32'(out),       32'd0);
        @(posedge clk); #2 reset_n = 1'b1;
        repeat (N16 + 4) @(negedge clk);

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 7))
                0: rd = 16'h8000;
                1: rd = 16'h0000;
                2: rd = 16'h7FFF;
                3: rd = 16'hFFFF;
                default: rd = 16'($urandom);
            endcase
            send(rd, 2'($urandom));
            finish_op($urandom_range(0, 3));
        end

        send8(8'h05, 2'b01, ao, av, al, bo, bv, bl);
        check("w8d1_out", 32'(ao), 32'h0000_00FB);
        check("w8d1_lat", 32'(al), 32'd9);
        check("w8d8_out", 32'(bo), 32'h0000_00FB);
        check("w8d8_lat", 32'(bl), 32'd2);
        send8(8'h80, 2'b10, ao, av, al, bo, bv, bl);
        check("w8_min_out", 32'(ao), 32'(minres8));
        check("w8_min_ovf", 32'(av), 32'd1);
        check("w8d8_min_out", 32'(bo), 32'(minres8));
        for (int i = 0; i < 30; i++) begin
            logic [7:0] x;
            logic [1:0] m;
            x = 8'($urandom);
            m = 2'($urandom);
            e = model({8'h00, x}, m, 8);
            send8(x, m, ao, av, al, bo, bv, bl);
            check("w8d1_rnd_out", 32'(ao), 32'(e[7:0]));
            check("w8d1_rnd_ovf", 32'(av), 32'(e[16]));
            check("w8d1_rnd_lat", 32'(al), 32'd9);
            check("w8d8_rnd_out", 32'(bo), 32'(e[7:0]));
            check("w8d8_rnd_ovf", 32'(bv), 32'(e[16]));
            check("w8d8_rnd_lat", 32'(bl), 32'd2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
